bcd_seg7_converter: RTL and testbench

//  Sequential, parametrised binary-to-BCD converter with built-in 7-segment encoding.

---
 rtl/bcd_seg7_converter_if.sv | 25 ++
 rtl/bcd_seg7_converter.sv | 129 ++++++++++++
 tb/tb_bcd_seg7_converter.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_seg7_converter_if.sv
// Handshake and result bundle between a binary source and bcd_seg7_converter.
// The source (master) drives start/bin; the converter (slave) returns the
// busy/done status together with the BCD digits, overflow flag and segments.
interface bcd_seg7_converter_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic                  ovf;
  logic [4*DIGITS-1:0]   bcd;
  logic [7*DIGITS-1:0]   seg;

  modport master (
    output start, bin,
    input  busy, done, ovf, bcd, seg
  );

  modport slave (
    input  start, bin,
    output busy, done, ovf, bcd, seg
  );
endinterface

// File: rtl/bcd_seg7_converter.sv
// Sequential binary-to-BCD converter with 7-segment encoding.
// Runs double-dabble (add-3 then shift) one input bit per clock under a
// start/busy/done handshake; results hold until the next done pulse.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank the segments of
// leading zero digits (digit 0 is always shown). bcd is never blanked.
module bcd_seg7_converter #(
  parameter int WIDTH          = 8,
  parameter int DIGITS         = 3,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bcd_seg7_converter_if.slave  bus
);

  localparam int         CW      = $clog2(WIDTH + 1);
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  typedef enum logic {IDLE, CONV} state_t;

  state_t                state;
  logic [WIDTH-1:0]      shreg;
  logic [WIDTH-1:0]      next_shreg;
  logic [4*DIGITS-1:0]   scratch;
  logic [4*DIGITS-1:0]   adjusted;
  logic [4*DIGITS-1:0]   next_scratch;
  logic [CW-1:0]         cnt;
  logic                  ovf_int;
  logic                  shift_out;
  logic [7*DIGITS-1:0]   seg_next;
`ifdef LEADING_ZERO_BLANK_EN
  logic                  seen;
`endif

  // Glyph for one decimal digit in the board's segment polarity.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h00;
    endcase
    return (SEG_ACTIVE_LOW != 0) ? ~p : p;
  endfunction

  // One double-dabble step: add 3 to every digit >= 5, then shift the whole
  // {scratch, shreg} chain left; the bit leaving the top digit is an overflow.
  always_comb begin
    adjusted = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
    {shift_out, next_scratch, next_shreg} = {adjusted, shreg, 1'b0};
  end

  // Segment image of the digits produced by the final iteration.
  always_comb begin
    seg_next = '0;
`ifdef LEADING_ZERO_BLANK_EN
    seen = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (next_scratch[4*i +: 4] != 4'd0) begin
        seen = 1'b1;
      end
      seg_next[7*i +: 7] = (seen || i == 0) ? glyph(next_scratch[4*i +: 4]) : SEG_OFF;
    end
`else
    for (int i = 0; i < DIGITS; i++) begin
      seg_next[7*i +: 7] = glyph(next_scratch[4*i +: 4]);
    end
`endif
  end

  // Control FSM with registered outputs; a reset aborts any running conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      scratch  <= '0;
      cnt      <= '0;
      ovf_int  <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.ovf  <= 1'b0;
      bus.bcd  <= '0;
      bus.seg  <= {DIGITS{SEG_OFF}};
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            shreg    <= bus.bin;
            scratch  <= '0;
            ovf_int  <= 1'b0;
            cnt      <= CW'(WIDTH);
            bus.busy <= 1'b1;
            state    <= CONV;
          end
        end
        CONV: begin
          shreg   <= next_shreg;
          scratch <= next_scratch;
          ovf_int <= ovf_int | shift_out;
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bus.bcd  <= next_scratch;
            bus.seg  <= seg_next;
            bus.ovf  <= ovf_int | shift_out;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seg7_converter.sv
// Testbench for bcd_seg7_converter: two instances (WIDTH=8 with 3 and 2
// digits, active-low segments) checked every cycle against a decimal
// arithmetic model, plus directed scenarios with literal expectations.
module tb_bcd_seg7_converter;

  localparam int WIDTH = 8;
  localparam logic [6:0] GLYPH [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int   tests = 0;
  int   fails = 0;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  bit   chk_en = 1'b0;

  logic       start_v [2];
  logic [7:0] bin_v   [2];

  bcd_seg7_converter_if #(.WIDTH(WIDTH), .DIGITS(3)) bus3 ();
  bcd_seg7_converter_if #(.WIDTH(WIDTH), .DIGITS(2)) bus2 ();

  assign bus3.start = start_v[0];
  assign bus3.bin   = bin_v[0];
  assign bus2.start = start_v[1];
  assign bus2.bin   = bin_v[1];

  bcd_seg7_converter #(.WIDTH(WIDTH), .DIGITS(3), .SEG_ACTIVE_LOW(1)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3.slave)
  );

  bcd_seg7_converter #(.WIDTH(WIDTH), .DIGITS(2), .SEG_ACTIVE_LOW(1)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  always #5 clk = ~clk;

  // Reference model state, one slot per instance.
  bit          m_busy   [2];
  int          m_left   [2];
  int          m_val    [2];
  logic        exp_done [2];
  logic        exp_ovf  [2];
  logic [11:0] exp_bcd  [2];
  logic [20:0] exp_seg  [2];

  function automatic int ndig(input int u);
    return (u == 0) ? 3 : 2;
  endfunction

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [11:0] bcd_of(input int v, input int nd);
    logic [11:0] r = '0;
    for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic logic [20:0] seg_off(input int nd);
    logic [20:0] r = '0;
    for (int i = 0; i < nd; i++) r[7*i +: 7] = 7'h7F;
    return r;
  endfunction

  function automatic logic [20:0] seg_of(input int v, input int nd);
    logic [20:0] r = '0;
    int msd = 0;
    int d;
    bit blank;
    for (int i = 0; i < nd; i++) if ((v / pow10(i)) % 10 != 0) msd = i;
    for (int i = 0; i < nd; i++) begin
      d = (v / pow10(i)) % 10;
`ifdef LEADING_ZERO_BLANK_EN
      blank = (i > msd);
`else
      blank = 1'b0;
`endif
      r[7*i +: 7] = blank ? 7'h7F : ~GLYPH[d];
    end
    return r;
  endfunction

  function automatic logic act_busy(input int u);
    return (u == 0) ? bus3.busy : bus2.busy;
  endfunction
  function automatic logic act_done(input int u);
    return (u == 0) ? bus3.done : bus2.done;
  endfunction
  function automatic logic act_ovf(input int u);
    return (u == 0) ? bus3.ovf : bus2.ovf;
  endfunction
  function automatic logic [11:0] act_bcd(input int u);
    return (u == 0) ? bus3.bcd : {4'h0, bus2.bcd};
  endfunction
  function automatic logic [20:0] act_seg(input int u);
    return (u == 0) ? bus3.seg : {7'h00, bus2.seg};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Model: a start seen while idle captures bin; WIDTH edges later the
  // decimal digits of the value (mod 10^DIGITS) appear with a done pulse.
  always @(posedge clk or negedge rst_n) begin
    for (int u = 0; u < 2; u++) begin
      if (!rst_n) begin
        m_busy[u]   = 1'b0;
        m_left[u]   = 0;
        exp_done[u] = 1'b0;
        exp_ovf[u]  = 1'b0;
        exp_bcd[u]  = '0;
        exp_seg[u]  = seg_off(ndig(u));
      end else begin
        exp_done[u] = 1'b0;
        if (m_busy[u]) begin
          m_left[u]--;
          if (m_left[u] == 0) begin
            m_busy[u]   = 1'b0;
            exp_done[u] = 1'b1;
            exp_bcd[u]  = bcd_of(m_val[u], ndig(u));
            exp_seg[u]  = seg_of(m_val[u], ndig(u));
            exp_ovf[u]  = (m_val[u] >= pow10(ndig(u)));
          end
        end else if (start_v[u]) begin
          m_busy[u] = 1'b1;
          m_left[u] = WIDTH;
          m_val[u]  = int'(bin_v[u]);
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int u = 0; u < 2; u++) begin
        checkOutput($sformatf("busy%0d", u), 32'(act_busy(u)), 32'(m_busy[u]));
        checkOutput($sformatf("done%0d", u), 32'(act_done(u)), 32'(exp_done[u]));
        checkOutput($sformatf("ovf%0d", u),  32'(act_ovf(u)),  32'(exp_ovf[u]));
        checkOutput($sformatf("bcd%0d", u),  32'(act_bcd(u)),  32'(exp_bcd[u]));
        checkOutput($sformatf("seg%0d", u),  32'(act_seg(u)),  32'(exp_seg[u]));
      end
    end
  end

  task automatic applyStimulus(input int u, input logic s, input logic [7:0] b);
    @(posedge clk);
    #2;
    start_v[u] = s;
    bin_v[u]   = b;
  endtask

  task automatic waitDone(input int u, output int cyc);
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (act_done(u)) begin
        cyc = i;
        return;
      end
    end
    tests++;
    fails++;
    $display("[TB] FAIL wait_done%0d: got no done, expected one within 40 cycles", u);
  endtask

  // Single start pulse; returns with outputs sampled in the done cycle.
  task automatic runOne(input int u, input logic [7:0] b, output int lat);
    applyStimulus(u, 1'b1, b);
    @(posedge clk);
    #2;
    start_v[u] = 1'b0;
    waitDone(u, lat);
  endtask

  int lat;
  int ndone;

  initial begin
    start_v = '{1'b0, 1'b0};
    bin_v   = '{8'd0, 8'd0};
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(bus3.busy), 32'd0);
    checkOutput("rst_done", 32'(bus3.done), 32'd0);
    checkOutput("rst_ovf",  32'(bus3.ovf),  32'd0);
    checkOutput("rst_bcd",  32'(bus3.bcd),  32'h000);
    checkOutput("rst_seg",  32'(bus3.seg),  32'h1FFFFF);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    runOne(0, 8'd255, lat);
    checkOutput("lat_255", 32'(lat), 32'd8);
    checkOutput("bcd_255", 32'(bus3.bcd), 32'h255);
    checkOutput("ovf_255", 32'(bus3.ovf), 32'd0);
    checkOutput("seg_255", 32'(bus3.seg), 32'({7'h24, 7'h12, 7'h12}));

    runOne(0, 8'd0, lat);
    checkOutput("bcd_0", 32'(bus3.bcd), 32'h000);
`ifdef LEADING_ZERO_BLANK_EN
    checkOutput("seg_0", 32'(bus3.seg), 32'({7'h7F, 7'h7F, 7'h40}));
`else
    checkOutput("seg_0", 32'(bus3.seg), 32'({7'h40, 7'h40, 7'h40}));
`endif

    runOne(1, 8'd200, lat);
    checkOutput("bcd_200_d2", 32'(bus2.bcd), 32'h00);
    checkOutput("ovf_200_d2", 32'(bus2.ovf), 32'd1);
    runOne(1, 8'd99, lat);
    checkOutput("bcd_99_d2", 32'(bus2.bcd), 32'h99);
    checkOutput("ovf_99_d2", 32'(bus2.ovf), 32'd0);

    // A second start during a conversion must be dropped.
    applyStimulus(0, 1'b1, 8'd255);
    @(posedge clk);
    #2;
    start_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    start_v[0] = 1'b1;
    bin_v[0]   = 8'd17;
    @(posedge clk);
    #2;
    start_v[0] = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus3.done) ndone++;
    end
    checkOutput("ignored_done_count", 32'(ndone), 32'd1);
    checkOutput("ignored_bcd", 32'(bus3.bcd), 32'h255);

    // Start held high: back-to-back conversions, one done per WIDTH+1 edges.
    applyStimulus(0, 1'b1, 8'd42);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      checkOutput("held_busy_xor_done", 32'(bus3.busy ^ bus3.done), 32'd1);
      if (bus3.done) begin
        ndone++;
        checkOutput("held_bcd", 32'(bus3.bcd), 32'h042);
      end
    end
    checkOutput("held_done_count", 32'(ndone), 32'd4);
    start_v[0] = 1'b0;
    repeat (12) @(posedge clk);

    // Reset in the middle of a conversion.
    applyStimulus(0, 1'b1, 8'd100);
    @(posedge clk);
    #2;
    start_v[0] = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(bus3.busy), 32'd0);
    checkOutput("abort_bcd",  32'(bus3.bcd),  32'h000);
    checkOutput("abort_seg",  32'(bus3.seg),  32'h1FFFFF);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus3.done) ndone++;
    end
    checkOutput("abort_no_done", 32'(ndone), 32'd0);
    runOne(0, 8'd137, lat);
    checkOutput("after_abort_lat", 32'(lat), 32'd8);
    checkOutput("after_abort_bcd", 32'(bus3.bcd), 32'h137);

    // Random traffic on both instances, biased toward digit boundaries.
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #2;
      for (int u = 0; u < 2; u++) begin
        start_v[u] = ($urandom_range(0, 3) == 0);
        case ($urandom_range(0, 9))
          0:       bin_v[u] = 8'd0;
          1:       bin_v[u] = 8'd99;
          2:       bin_v[u] = 8'd100;
          3:       bin_v[u] = 8'd255;
          4:       bin_v[u] = 8'd199;
          default: bin_v[u] = 8'($urandom_range(0, 255));
        endcase
      end
    end
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    repeat (12) @(posedge clk);
    #6;
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
